// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg: shared sizes and types for the memory request arbiter
package mem_req_arbiter_pkg;
  localparam int ADDR_WID = 5;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH = 2**ADDR_WID;
  localparam int MAX_REQ = 4;
  typedef enum logic {INIT, SERVE} state_e;
  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;
endpackage

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: requester-side valid/ready bus with read response
interface mem_req_arbiter_if import mem_req_arbiter_pkg::*; #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] req_we;
  logic [NUM_REQ*ADDR_WID-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  modport master(output req_valid, req_we, req_addr, req_wdata, input req_ready, rsp_valid, rsp_rdata);
  modport slave(input req_valid, req_we, req_addr, req_wdata, output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/mem_req_arbiter_rr_grant.sv
// mem_req_arbiter_rr_grant: combinational round-robin pick starting at prio
module mem_req_arbiter_rr_grant import mem_req_arbiter_pkg::*; #(parameter int NUM_REQ = 2) (
  input  logic [NUM_REQ-1:0] valid,
  input  req_id_t            prio,
  output logic [NUM_REQ-1:0] grant,
  output req_id_t            idx,
  output logic               any
);
  // walk from the farthest slot back toward prio so the nearest valid wins
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid[(int'(prio) + k) % NUM_REQ]) begin
        idx = req_id_t'((int'(prio) + k) % NUM_REQ);
        any = 1'b1;
      end
    end
    grant = any ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: clears simple_mem after reset, then round-robin shares its port
module mem_req_arbiter import mem_req_arbiter_pkg::*; #(parameter int NUM_REQ = 2) (
  input  logic                  clk,
  input  logic                  rst,
  mem_req_arbiter_if.slave      bus,
  output logic                  init_done,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WID-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  state_e state_q, state_d;
  logic [ADDR_WID-1:0] init_cnt_q, init_cnt_d;
  req_id_t prio_q, prio_d, rd_owner_q, rd_owner_d, g_idx;
  logic rd_pend_q, rd_pend_d, g_any;
  logic [NUM_REQ-1:0] g_onehot, ready;
  logic wr_en, rd_en;
  logic [ADDR_WID-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;

  mem_req_arbiter_rr_grant #(.NUM_REQ(NUM_REQ)) u_grant (
    .valid(bus.req_valid),
    .prio (prio_q),
    .grant(g_onehot),
    .idx  (g_idx),
    .any  (g_any)
  );

  // sweep-clear in INIT, otherwise route the granted requester onto the memory port
  always_comb begin
    state_d = state_q;
    init_cnt_d = init_cnt_q;
    prio_d = prio_q;
    rd_pend_d = 1'b0;
    rd_owner_d = rd_owner_q;
    ready = '0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr = '0;
    wdata = '0;
    if (state_q == INIT) begin
      wr_en = 1'b1;
      addr = init_cnt_q;
      init_cnt_d = init_cnt_q + 1'b1;
      state_d = (init_cnt_q == ADDR_WID'(DEPTH - 1)) ? SERVE : INIT;
    end else if (g_any) begin
      ready = g_onehot;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (g_onehot[i]) begin
          wr_en = bus.req_we[i];
          addr = bus.req_addr[i*ADDR_WID +: ADDR_WID];
          wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      rd_en = !wr_en;
      rd_pend_d = !wr_en;
      rd_owner_d = g_idx;
      prio_d = (g_idx == req_id_t'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
    end
  end

  // everything reads zero while reset is held
  always_comb begin
    bus.req_ready = rst ? '0 : ready;
    mem_wr_en = !rst && wr_en;
    mem_rd_en = !rst && rd_en;
    mem_addr = rst ? '0 : addr;
    mem_wdata = rst ? '0 : wdata;
    init_done = !rst && state_q == SERVE;
    bus.rsp_valid = (rd_pend_q && !rst) ? NUM_REQ'(1) << rd_owner_q : '0;
    bus.rsp_rdata = (rd_pend_q && !rst) ? mem_rdata : '0;
  end

  // state, sweep counter, priority pointer and one-cycle read-response register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      init_cnt_q <= '0;
      prio_q <= '0;
      rd_pend_q <= 1'b0;
      rd_owner_q <= '0;
    end else begin
      state_q <= state_d;
      init_cnt_q <= init_cnt_d;
      prio_q <= prio_d;
      rd_pend_q <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end
endmodule
